// File: rtl/risc_control_fsm.sv
// Moore sequencer for the Simple RISC Machine: fetch, PC increment, decode, then per-instruction datapath/memory control.
// Outputs depend on state only; BRANCH also folds in b_cond and the status flags to choose the PC update.
module risc_control_fsm #(
   parameter int STATE_W = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   input  logic [2:0] b_cond,
   input  logic       Z,
   input  logic       N,
   input  logic       V,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       write,
   output logic       load_ir,
   output logic       load_pc,
   output logic       reset_pc,
   output logic [1:0] pc_sel,
   output logic       addr_sel,
   output logic       load_addr,
   output logic [1:0] mem_cmd,
   output logic       halted
);

   localparam logic [2:0] NS_RN = 3'b100;
   localparam logic [2:0] NS_RD = 3'b010;
   localparam logic [2:0] NS_RM = 3'b001;
   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM,
      S_GET_A, S_GET_B, S_ALU_A0, S_ALU, S_WR_RD, S_CMP,
      S_ADDR, S_LD_ADDR, S_MEM_RD, S_WR_MEM, S_GET_RD, S_PASS_B,
      S_MEM_WR, S_BRANCH, S_LINK, S_BRANCH_AL, S_BX_PC, S_HALT
   } state_t;

   state_t state, state_next;
   logic   taken;

   always_ff @(posedge clk) begin
      if (reset) state <= S_RST;
      else       state <= state_next;
   end

   always_comb begin
      case (b_cond)
         3'b000:  taken = 1'b1;
         3'b001:  taken = Z;
         3'b010:  taken = ~Z;
         3'b011:  taken = N ^ V;
         3'b100:  taken = (N ^ V) | Z;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state;
      nsel       = 3'b000;
      vsel       = 2'b00;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      asel       = 1'b0;
      bsel       = 1'b0;
      write      = 1'b0;
      load_ir    = 1'b0;
      load_pc    = 1'b0;
      reset_pc   = 1'b0;
      pc_sel     = 2'b00;
      addr_sel   = 1'b0;
      load_addr  = 1'b0;
      mem_cmd    = MEM_NONE;
      halted     = 1'b0;
      case (state)
         S_RST: begin
            reset_pc   = 1'b1;
            load_pc    = 1'b1;
            state_next = S_IF1;
         end
         S_IF1: begin
            addr_sel   = 1'b1;
            mem_cmd    = MEM_READ;
            state_next = S_IF2;
         end
         S_IF2: begin
            addr_sel   = 1'b1;
            mem_cmd    = MEM_READ;
            load_ir    = 1'b1;
            state_next = S_UPD_PC;
         end
         S_UPD_PC: begin
            load_pc    = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            case ({opcode, op}) inside
               5'b110_10:                   state_next = S_WR_IMM;
               5'b110_00, 5'b101_11:        state_next = S_GET_B;
               5'b101_00, 5'b101_10,
               5'b101_01, 5'b011_00,
               5'b100_00:                   state_next = S_GET_A;
               5'b001_00:                   state_next = S_BRANCH;
               5'b010_11, 5'b010_10:        state_next = S_LINK;
               5'b010_00:                   state_next = S_GET_RD;
               5'b111_??:                   state_next = S_HALT;
               default:                     state_next = S_IF1;
            endcase
         end
         S_WR_IMM: begin
            nsel       = NS_RN;
            vsel       = 2'b01;
            write      = 1'b1;
            state_next = S_IF1;
         end
         S_GET_A: begin
            nsel       = NS_RN;
            loada      = 1'b1;
            state_next = (opcode == 3'b011 || opcode == 3'b100) ? S_ADDR : S_GET_B;
         end
         S_GET_B: begin
            nsel  = NS_RM;
            loadb = 1'b1;
            // MOV reg / MVN skip A; CMP only needs the flags
            if (opcode == 3'b110 || (opcode == 3'b101 && op == 2'b11)) state_next = S_ALU_A0;
            else if (op == 2'b01)                                      state_next = S_CMP;
            else                                                       state_next = S_ALU;
         end
         S_ALU_A0: begin
            asel       = 1'b1;
            loadc      = 1'b1;
            state_next = S_WR_RD;
         end
         S_ALU: begin
            loadc      = 1'b1;
            state_next = S_WR_RD;
         end
         S_WR_RD: begin
            nsel       = NS_RD;
            write      = 1'b1;
            state_next = S_IF1;
         end
         S_CMP: begin
            loads      = 1'b1;
            state_next = S_IF1;
         end
         S_ADDR: begin
            bsel       = 1'b1;
            loadc      = 1'b1;
            state_next = S_LD_ADDR;
         end
         S_LD_ADDR: begin
            load_addr  = 1'b1;
            state_next = (opcode == 3'b011) ? S_MEM_RD : S_GET_RD;
         end
         S_MEM_RD: begin
            mem_cmd    = MEM_READ;
            state_next = S_WR_MEM;
         end
         S_WR_MEM: begin
            mem_cmd    = MEM_READ;
            nsel       = NS_RD;
            vsel       = 2'b10;
            write      = 1'b1;
            state_next = S_IF1;
         end
         S_GET_RD: begin
            nsel       = NS_RD;
            loadb      = 1'b1;
            state_next = S_PASS_B;
         end
         S_PASS_B: begin
            asel       = 1'b1;
            loadc      = 1'b1;
            state_next = (opcode == 3'b100) ? S_MEM_WR : S_BX_PC;
         end
         S_MEM_WR: begin
            mem_cmd    = MEM_WRITE;
            state_next = S_IF1;
         end
         S_BRANCH: begin
            load_pc    = taken;
            pc_sel     = taken ? 2'b01 : 2'b00;
            state_next = S_IF1;
         end
         S_LINK: begin
            nsel       = NS_RN;
            vsel       = 2'b11;
            write      = 1'b1;
            state_next = (op == 2'b11) ? S_BRANCH_AL : S_GET_RD;
         end
         S_BRANCH_AL: begin
            load_pc    = 1'b1;
            pc_sel     = 2'b01;
            state_next = S_IF1;
         end
         S_BX_PC: begin
            load_pc    = 1'b1;
            pc_sel     = 2'b10;
            state_next = S_IF1;
         end
         S_HALT: begin
            halted     = 1'b1;
            state_next = S_HALT;
         end
         default: state_next = S_RST;
      endcase
   end

endmodule
